// File: rtl/start_ack_pkg.sv
// Shared types and default parameters for the start/ack sequencer.
package start_ack_pkg;

    localparam int unsigned TMO_W_DEF     = 8;
    localparam int unsigned TIMEOUT_DEF   = 16;
    localparam int unsigned MAX_RETRY_DEF = 3;
    localparam int unsigned RTY_W_DEF     = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        BACKOFF = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_e;

    // States in which a transaction is in flight.
    function automatic logic is_busy(input state_e s);
        return (s == WAIT) || (s == BACKOFF) || (s == DONE);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: remembers last sampled level, flags 0->1.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic din_q;

    // Previous-cycle level; cleared by reset so a level already high counts as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise_c = din & ~din_q;

endmodule

// File: rtl/start_ack_sequencer.sv
// Start-triggered req/ack sequencer with timeout, bounded retry and sticky error.
module start_ack_sequencer
    import start_ack_pkg::*;
#(
    parameter int unsigned TMO_W     = TMO_W_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
    parameter int unsigned RTY_W     = RTY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ack,
    input  logic             err_clr,
    output logic             req,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             overrun,
    output logic [RTY_W-1:0] retry_cnt
);

    // Reject parameter sets where the timer compare could wrap or the retry count overflows.
    if (TIMEOUT < 2 || 64'(TIMEOUT) > ((64'(1) << TMO_W) - 64'(1))) begin : g_bad_timeout
        $error("start_ack_sequencer: TIMEOUT must be in 2 .. 2**TMO_W-1");
    end
    if (64'(MAX_RETRY) > ((64'(1) << RTY_W) - 64'(1))) begin : g_bad_retry
        $error("start_ack_sequencer: MAX_RETRY does not fit in RTY_W bits");
    end

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    state_e             state;
    state_e             state_d;
    logic [TMO_W-1:0]   timer;
    logic [TMO_W-1:0]   timer_d;
    logic [RTY_W-1:0]   retry_d;
    logic               req_d;
    logic               done_d;
    logic               err_d;
    logic               busy_d;
    logic               overrun_d;
    logic               start_rise;
    logic               tmo_hit;
    logic               retry_left;

    rise_detect u_rise_detect (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (start),
        .rise_c (start_rise)
    );

    assign tmo_hit    = (timer == TMO_LAST);
    assign retry_left = (retry_cnt != RTY_MAX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; ack beats a coincident timeout.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start_rise) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ack) begin
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d = retry_left ? BACKOFF : ERR;
                end
            end
            BACKOFF: state_d = WAIT;
            DONE:    state_d = IDLE;
            ERR: begin
                if (err_clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; outputs decode the state being entered.
    always_comb begin
        timer_d   = timer;
        retry_d   = retry_cnt;
        req_d     = (state_d == WAIT);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERR);
        busy_d    = is_busy(state_d);
        overrun_d = start_rise && is_busy(state);
        unique case (state)
            IDLE: begin
                if (start_rise) begin
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            WAIT: begin
                timer_d = timer + TMO_W'(1);
                if (!ack && tmo_hit && retry_left) begin
                    retry_d = retry_cnt + RTY_W'(1);
                end
            end
            BACKOFF: timer_d = '0;
            default: ;
        endcase
    end

    // Registered outputs, timer and retry counter; reset drops req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            retry_cnt <= '0;
            req       <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            timer     <= timer_d;
            retry_cnt <= retry_d;
            req       <= req_d;
            done      <= done_d;
            err       <= err_d;
            busy      <= busy_d;
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_start_ack_sequencer.sv
// Directed, table-driven bench for start_ack_sequencer (TIMEOUT=4, MAX_RETRY=3).
module tb_start_ack_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ack;
    logic       err_clr;
    logic       req;
    logic       done;
    logic       err;
    logic       busy;
    logic       overrun;
    logic [1:0] retry_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Inputs applied before an edge and the outputs required just after it.
    // exp = {req, done, err, busy, overrun, retry_cnt[1:0]}
    typedef struct {
        string      tag;
        logic       start;
        logic       ack;
        logic       err_clr;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    start_ack_sequencer #(
        .TMO_W     (8),
        .TIMEOUT   (4),
        .MAX_RETRY (3),
        .RTY_W     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ack       (ack),
        .err_clr   (err_clr),
        .req       (req),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .overrun   (overrun),
        .retry_cnt (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void add(input string tag, input logic s, input logic a, input logic c,
                                input logic r, input logic d, input logic e, input logic b,
                                input logic o, input logic [1:0] rc);
        vec_t v;
        v.tag     = tag;
        v.start   = s;
        v.ack     = a;
        v.err_clr = c;
        v.exp     = {r, d, e, b, o, rc};
        vecs.push_back(v);
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] got;
        got = {req, done, err, busy, overrun, retry_cnt};
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at %0t: req/done/err/busy/ovr/rty got %b required %b",
                     tag, $time, got, exp);
        end
    endtask

    initial begin
        // Clean handshake: ack on the second WAIT edge, done the cycle after.
        add("clean_start",  1, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        add("clean_wait",   1, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        add("clean_ack",    1, 1, 0,  0, 1, 0, 1, 0, 2'd0);
        add("clean_idle",   0, 0, 0,  0, 0, 0, 0, 0, 2'd0);
        add("idle_ack_ign", 0, 1, 0,  0, 0, 0, 0, 0, 2'd0);

        // Timeout, one backoff (ack ignored there), then success on 2nd retry cycle.
        add("to_start",     1, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        for (int k = 0; k < 3; k++) add("to_wait0", 1, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        add("to_backoff",   1, 0, 0,  0, 0, 0, 1, 0, 2'd1);
        add("to_bo_ackign", 1, 1, 0,  1, 0, 0, 1, 0, 2'd1);
        add("to_wait1",     1, 0, 0,  1, 0, 0, 1, 0, 2'd1);
        add("to_ack",       1, 1, 0,  0, 1, 0, 1, 0, 2'd1);
        add("to_idle",      0, 0, 0,  0, 0, 0, 0, 0, 2'd1);

        // Retry exhaustion: four 4-cycle windows separated by 1-cycle gaps, then ERR.
        add("exh_start",    1, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        for (int k = 0; k < 3; k++) add("exh_wait0", 1, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        for (int r = 1; r <= 3; r++) begin
            add("exh_backoff", 1, 0, 0,  0, 0, 0, 1, 0, 2'(r));
            for (int k = 0; k < 4; k++) add("exh_wait", 1, 0, 0,  1, 0, 0, 1, 0, 2'(r));
        end
        add("exh_err",      1, 0, 0,  0, 0, 1, 0, 0, 2'd3);
        add("err_hold",     0, 0, 0,  0, 0, 1, 0, 0, 2'd3);
        add("err_rise_ign", 1, 0, 0,  0, 0, 1, 0, 0, 2'd3);
        add("err_hold2",    0, 0, 0,  0, 0, 1, 0, 0, 2'd3);
        add("err_clr_rise", 1, 0, 1,  0, 0, 0, 0, 0, 2'd3);
        add("clr_no_start", 1, 0, 0,  0, 0, 0, 0, 0, 2'd3);
        add("clr_idle",     0, 0, 0,  0, 0, 0, 0, 0, 2'd3);
        add("clr_outside",  0, 0, 1,  0, 0, 0, 0, 0, 2'd3);

        // Ack coincident with the timeout edge wins.
        add("sim_start",    1, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        for (int k = 0; k < 3; k++) add("sim_wait", 1, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        add("sim_ack_tmo",  1, 1, 0,  0, 1, 0, 1, 0, 2'd0);
        add("sim_idle",     0, 0, 0,  0, 0, 0, 0, 0, 2'd0);

        // Overrun in WAIT and in DONE; no second transaction.
        add("ovr_start",    1, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        add("ovr_low",      0, 0, 0,  1, 0, 0, 1, 0, 2'd0);
        add("ovr_wait",     1, 0, 0,  1, 0, 0, 1, 1, 2'd0);
        add("ovr_ack",      0, 1, 0,  0, 1, 0, 1, 0, 2'd0);
        add("ovr_done",     1, 0, 0,  0, 0, 0, 0, 1, 2'd0);
        add("ovr_no_req",   1, 0, 0,  0, 0, 0, 0, 0, 2'd0);
        add("ovr_idle",     0, 0, 0,  0, 0, 0, 0, 0, 2'd0);

        rst_n   = 1'b0;
        start   = 1'b0;
        ack     = 1'b0;
        err_clr = 1'b0;
        #2;
        check("reset_state", 7'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 7'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            start   = vecs[i].start;
            ack     = vecs[i].ack;
            err_clr = vecs[i].err_clr;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].exp);
        end

        // Reset during WAIT: req drops without a clock edge, no done, restart on release.
        @(negedge clk);
        start   = 1'b1;
        ack     = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        check("rst_wait_entry", {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", 7'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_hold", 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_low", 7'b0);
        @(posedge clk);
        #1;
        check("rst_restart", {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        check("rst_done", {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_idle", 7'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
